// File: rtl/instr_mem_pkg.sv
// Shared types, constants and the address legality check for the instruction-fetch responder.
// The same check is applied to fetch and load addresses so both paths agree on which words exist.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Arguments are widened to 64 bits so that neither the subtraction nor the shift
  // can wrap inside the narrower address width.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] depth);
    logic [63:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus between the core's fetch stage (master) and the responder (slave).
// A request is accepted in a cycle where fetch_req and fetch_gnt are both high; the response
// is a single-cycle fetch_rvalid pulse, with fetch_rdata and fetch_err qualified by it.
interface instr_mem_responder_if #(
  parameter int BITSIZE = 32
);

  logic               fetch_req;
  logic [BITSIZE-1:0] fetch_addr;
  logic               fetch_gnt;
  logic [31:0]        fetch_rdata;
  logic               fetch_rvalid;
  logic               fetch_err;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_gnt,
    input  fetch_rdata,
    input  fetch_rvalid,
    input  fetch_err
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_gnt,
    output fetch_rdata,
    output fetch_rvalid,
    output fetch_err
  );

endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction RAM: one synchronous write port and one registered read port.
// A read and write of the same word in one cycle returns the previous contents.
module instr_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: grants one word fetch at a time, waits a fixed number of
// cycles, then returns the RAM word (or a NOP with error for illegal addresses).
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int                 BITSIZE     = 32,
  parameter int                 DEPTH       = 256,
  parameter int                 WAIT_STATES = 3,
  parameter logic [BITSIZE-1:0] BASE_ADDR   = '0
) (
  input  logic               clk,
  input  logic               rst_i,
  instr_mem_responder_if.slave fetch_if,
  input  logic               load_we_i,
  input  logic [BITSIZE-1:0] load_addr_i,
  input  logic [31:0]        load_data_i,
  output state_t             state_o
);

  localparam int AW = $clog2(DEPTH);

  state_t             state_q;
  logic [3:0]         count_q;
  logic [BITSIZE-1:0] addr_q;
  logic               err_q;
  logic [31:0]        hold_q;

  logic               accept;
  logic               fetch_ok;
  logic               load_ok;
  logic [AW-1:0]      fetch_idx;
  logic [AW-1:0]      addr_idx;
  logic [AW-1:0]      load_idx;
  logic [AW-1:0]      rd_idx;
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        ram_rdata;
  logic [31:0]        resp_data;

  assign fetch_ok  = addr_ok(64'(fetch_if.fetch_addr), 64'(BASE_ADDR), 64'(DEPTH));
  assign load_ok   = addr_ok(64'(load_addr_i), 64'(BASE_ADDR), 64'(DEPTH));
  assign fetch_idx = AW'((fetch_if.fetch_addr - BASE_ADDR) >> 2);
  assign addr_idx  = AW'((addr_q - BASE_ADDR) >> 2);
  assign load_idx  = AW'((load_addr_i - BASE_ADDR) >> 2);

  assign fetch_if.fetch_gnt = (state_q == IDLE) && !rst_i;
  assign accept             = fetch_if.fetch_req && fetch_if.fetch_gnt;

  // The RAM read is launched in the cycle that enters RESP so its registered output
  // lines up with the response; with no wait states that is the grant cycle itself.
  assign rd_idx = (state_q == IDLE) ? fetch_idx : addr_idx;
  assign rd_en  = (accept && (WAIT_STATES == 0) && fetch_ok) ||
                  ((state_q == WAIT) && (count_q == 4'd1) && !err_q);
  assign wr_en  = load_we_i && load_ok;

  instr_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (load_idx),
    .wdata_i (load_data_i),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= fetch_if.fetch_addr;
            err_q  <= !fetch_ok;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              count_q <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          hold_q  <= resp_data;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outside RESP the data bus keeps showing the last response.
  assign resp_data             = err_q ? NOP_INSTR : ram_rdata;
  assign fetch_if.fetch_rvalid = (state_q == RESP);
  assign fetch_if.fetch_err    = (state_q == RESP) && err_q;
  assign fetch_if.fetch_rdata  = (state_q == RESP) ? resp_data : hold_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: one instance with 3 wait states, one with none, a word
// model of each RAM and a response scoreboard per instance.
module tb_instr_mem_responder;
  import instr_mem_pkg::*;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  instr_mem_responder_if #(.BITSIZE(32)) fif ();
  instr_mem_responder_if #(.BITSIZE(32)) fif0 ();

  logic        ld_we_a, ld_we_b;
  logic [31:0] ld_addr_a, ld_addr_b, ld_data_a, ld_data_b;
  state_t      st_a, st_b;

  instr_mem_responder #(
    .BITSIZE(32), .DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)
  ) dut_a (
    .clk(clk), .rst_i(rst), .fetch_if(fif.slave),
    .load_we_i(ld_we_a), .load_addr_i(ld_addr_a), .load_data_i(ld_data_a),
    .state_o(st_a)
  );

  instr_mem_responder #(
    .BITSIZE(32), .DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) dut_b (
    .clk(clk), .rst_i(rst), .fetch_if(fif0.slave),
    .load_we_i(ld_we_b), .load_addr_i(ld_addr_b), .load_data_i(ld_data_b),
    .state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp0_q[$];
  logic [31:0]  mem_m [2][256];
  logic [W-1:0] e_a, e_b;
  int n_cmp = 0;
  int n_bad = 0;
  int rv_a = 0;
  int rv_b = 0;

  // Expected response for a 256-word RAM at byte address 0.
  function automatic logic [W-1:0] exp_fetch(input int sel, input logic [31:0] addr);
    if (addr[1:0] != 2'b00 || addr >= 32'd1024) return {1'b1, 32'h0000_0013};
    return {1'b0, mem_m[sel][addr[9:2]]};
  endfunction

  always @(negedge clk) begin
    if (fif.fetch_rvalid === 1'b1) begin
      rv_a++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_a_unexpected: got err=%b rdata=%h, required no response",
                 fif.fetch_err, fif.fetch_rdata);
      end else begin
        e_a = exp_q.pop_front();
        if ({fif.fetch_err, fif.fetch_rdata} !== e_a) begin
          n_bad++;
          $display("FAIL rsp_a: got err=%b rdata=%h, required err=%b rdata=%h",
                   fif.fetch_err, fif.fetch_rdata, e_a[32], e_a[31:0]);
        end
      end
    end
    if (fif0.fetch_rvalid === 1'b1) begin
      rv_b++;
      n_cmp++;
      if (exp0_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_b_unexpected: got err=%b rdata=%h, required no response",
                 fif0.fetch_err, fif0.fetch_rdata);
      end else begin
        e_b = exp0_q.pop_front();
        if ({fif0.fetch_err, fif0.fetch_rdata} !== e_b) begin
          n_bad++;
          $display("FAIL rsp_b: got err=%b rdata=%h, required err=%b rdata=%h",
                   fif0.fetch_err, fif0.fetch_rdata, e_b[32], e_b[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic do_load(input int sel, input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      ld_we_a = 1'b1; ld_addr_a = addr; ld_data_a = data;
    end else begin
      ld_we_b = 1'b1; ld_addr_b = addr; ld_data_b = data;
    end
    if (addr[1:0] == 2'b00 && addr < 32'd1024) mem_m[sel][addr[9:2]] = data;
    @(posedge clk); #1;
    ld_we_a = 1'b0;
    ld_we_b = 1'b0;
  endtask

  task automatic do_fetch(input int sel, input logic [31:0] addr,
                          output logic g, output int lat);
    if (sel == 0) begin
      fif.fetch_req = 1'b1; fif.fetch_addr = addr;
    end else begin
      fif0.fetch_req = 1'b1; fif0.fetch_addr = addr;
    end
    @(negedge clk);
    g = (sel == 0) ? fif.fetch_gnt : fif0.fetch_gnt;
    if (g === 1'b1) begin
      if (sel == 0) exp_q.push_back(exp_fetch(0, addr));
      else exp0_q.push_back(exp_fetch(1, addr));
    end
    @(posedge clk); #1;
    fif.fetch_req  = 1'b0;
    fif0.fetch_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (((sel == 0) ? fif.fetch_rvalid : fif0.fetch_rvalid) === 1'b1) lat = k;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (fif.fetch_gnt !== 1'b0 || fif0.fetch_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gnt_low: got %b/%b, required 0/0", fif.fetch_gnt, fif0.fetch_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fif.fetch_gnt, fif.fetch_rvalid, fif.fetch_err, fif.fetch_rdata} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b rvalid=%b err=%b rdata=%h, required 1 0 0 00000000",
               fif.fetch_gnt, fif.fetch_rvalid, fif.fetch_err, fif.fetch_rdata);
    end
    n_cmp++;
    if (st_a !== IDLE || fif0.fetch_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d gnt_b=%b, required 0 1", st_a, fif0.fetch_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_fetch;
    logic g;
    int   lat;
    for (int i = 0; i < 256; i++) do_load(0, 32'(i * 4), $urandom);
    do_load(0, 32'h0, 32'h7C7F_E2B7);
    do_load(0, 32'h4, 32'h0011_8193);
    do_fetch(0, 32'h0, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 4) begin
      n_bad++;
      $display("FAIL basic_w0_timing: got gnt=%b latency=%0d, required 1 4", g, lat);
    end
    do_fetch(0, 32'h4, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 4) begin
      n_bad++;
      $display("FAIL basic_w1_timing: got gnt=%b latency=%0d, required 1 4", g, lat);
    end
    @(negedge clk);
    n_cmp++;
    if ({fif.fetch_rvalid, fif.fetch_err, fif.fetch_rdata} !== {2'b00, 32'h0011_8193}) begin
      n_bad++;
      $display("FAIL rdata_hold: got rvalid=%b err=%b rdata=%h, required 0 0 00118193",
               fif.fetch_rvalid, fif.fetch_err, fif.fetch_rdata);
    end
    @(posedge clk); #1;
    do_fetch(0, 32'h3FC, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 4) begin
      n_bad++;
      $display("FAIL last_word_timing: got gnt=%b latency=%0d, required 1 4", g, lat);
    end
  endtask

  task automatic test_error_fetch;
    logic g;
    int   lat;
    logic [31:0] addrs [4];
    addrs = '{32'h2, 32'h400, 32'h3FF, 32'hFFFF_FFFC};
    foreach (addrs[i]) begin
      do_fetch(0, addrs[i], g, lat);
      n_cmp++;
      if (g !== 1'b1 || lat != 4) begin
        n_bad++;
        $display("FAIL err_timing[%h]: got gnt=%b latency=%0d, required 1 4", addrs[i], g, lat);
      end
    end
    // Illegal loads must not alias onto existing words.
    do_load(0, 32'h400, 32'hDEAD_BEEF);
    do_load(0, 32'h5, 32'hCAFE_F00D);
    do_fetch(0, 32'h0, g, lat);
    do_fetch(0, 32'h4, g, lat);
  endtask

  task automatic test_back_to_back;
    logic [31:0] list [4];
    int i, last, r0;
    list = '{32'h10, 32'h20, 32'h30, 32'h40};
    i = 0;
    last = -1;
    r0 = rv_a;
    fif.fetch_req = 1'b1;
    fif.fetch_addr = list[0];
    for (int c = 0; c < 60 && i < 4; c++) begin
      @(negedge clk);
      if (fif.fetch_gnt === 1'b1) begin
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 5) begin
            n_bad++;
            $display("FAIL b2b_gnt_spacing: got %0d cycles, required 5", cyc - last);
          end
        end
        exp_q.push_back(exp_fetch(0, list[i]));
        last = cyc;
        i++;
        @(posedge clk); #1;
        if (i < 4) fif.fetch_addr = list[i];
        else fif.fetch_req = 1'b0;
      end
    end
    fif.fetch_req = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    n_cmp++;
    if (i != 4 || rv_a - r0 != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got grants=%0d responses=%0d, required 4 4", i, rv_a - r0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch;
    logic g;
    int   lat, r0;
    fif.fetch_req = 1'b1;
    fif.fetch_addr = 32'h8;
    @(negedge clk);
    n_cmp++;
    if (fif.fetch_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_gnt: got %b, required 1", fif.fetch_gnt);
    end
    @(posedge clk); #1;
    fif.fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = rv_a;
    @(negedge clk);
    n_cmp++;
    if (fif.fetch_gnt !== 1'b1 || st_a !== IDLE || fif.fetch_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_release: got gnt=%b state=%0d rdata=%h, required 1 0 00000000",
               fif.fetch_gnt, st_a, fif.fetch_rdata);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rv_a != r0) begin
      n_bad++;
      $display("FAIL rst_mid_dropped: got %0d responses, required 0", rv_a - r0);
    end
    @(posedge clk); #1;
    do_fetch(0, 32'h8, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 4) begin
      n_bad++;
      $display("FAIL rst_mid_refetch: got gnt=%b latency=%0d, required 1 4", g, lat);
    end
  endtask

  task automatic test_read_before_write;
    logic g;
    int   lat;
    do_load(0, 32'h14, 32'hA5A5_0001);
    fif.fetch_req = 1'b1;
    fif.fetch_addr = 32'h14;
    @(negedge clk);
    n_cmp++;
    if (fif.fetch_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rbw_gnt: got %b, required 1", fif.fetch_gnt);
    end
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    @(posedge clk); #1;
    fif.fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ld_we_a = 1'b1; ld_addr_a = 32'h14; ld_data_a = 32'h5A5A_0002;
    mem_m[0][5] = 32'h5A5A_0002;
    @(posedge clk); #1;
    ld_we_a = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    do_fetch(0, 32'h14, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 4) begin
      n_bad++;
      $display("FAIL rbw_refetch: got gnt=%b latency=%0d, required 1 4", g, lat);
    end
  endtask

  task automatic test_random;
    logic g;
    int   lat, r;
    logic [31:0] a;
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
      else a = 32'($urandom_range(0, 255) * 4);
      if (r == 2) do_load(0, a, $urandom);
      do_fetch(0, a, g, lat);
      n_cmp++;
      if (g !== 1'b1 || lat != 4) begin
        n_bad++;
        $display("FAIL rand_timing[%h]: got gnt=%b latency=%0d, required 1 4", a, g, lat);
      end
    end
  endtask

  task automatic test_zero_wait;
    logic g;
    int   lat;
    do_load(1, 32'h0, 32'h0BAD_F00D);
    do_load(1, 32'h3, 32'h1111_1111);
    do_load(1, 32'h10, 32'h2222_3333);
    do_fetch(1, 32'h0, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL zw_word0_timing: got gnt=%b latency=%0d, required 1 1", g, lat);
    end
    do_fetch(1, 32'h2, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL zw_err_timing: got gnt=%b latency=%0d, required 1 1", g, lat);
    end
    do_fetch(1, 32'h10, g, lat);
    n_cmp++;
    if (g !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL zw_word4_timing: got gnt=%b latency=%0d, required 1 1", g, lat);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    fif.fetch_req = 1'b0;  fif.fetch_addr = 32'h0;
    fif0.fetch_req = 1'b0; fif0.fetch_addr = 32'h0;
    ld_we_a = 1'b0; ld_addr_a = 32'h0; ld_data_a = 32'h0;
    ld_we_b = 1'b0; ld_addr_b = 32'h0; ld_data_b = 32'h0;

    test_reset;
    test_basic_fetch;
    test_error_fetch;
    test_back_to_back;
    test_reset_mid_fetch;
    test_read_before_write;
    test_random;
    test_zero_wait;

    for (int c = 0; c < 20 && (exp_q.size() != 0 || exp0_q.size() != 0); c++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0",
               exp_q.size(), exp0_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
